// File: rtl/layer_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// layer_dispatch_pkg
// Shared types and constants for the layer dispatcher:
//   state_t         - sequencer states (IDLE, START, STREAM, DRAIN)
//   KIND_*          - encodings of the in_kind stream tag
//   RESULT_COUNT_W  - width of the per-layer result counter
// ---------------------------------------------------------------------------
package layer_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [1:0] KIND_OP   = 2'd0;
    localparam logic [1:0] KIND_WT   = 2'd1;
    localparam logic [1:0] KIND_BIAS = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    localparam int RESULT_COUNT_W = 16;

endpackage : layer_dispatch_pkg

// File: rtl/dispatch_result_fifo.sv
// ---------------------------------------------------------------------------
// dispatch_result_fifo
// First-word-fall-through FIFO that buffers engine results.
// The pointers carry one extra wrap bit so that full and empty can be told
// apart without a separate occupancy register.
// Ports:
//   clock, reset  - clock, asynchronous active-low reset
//   flush         - empties the FIFO next cycle (has priority over push/pop)
//   push, wr_data - write one entry (the caller guarantees room, or a pop)
//   pop           - remove the head entry (ignored when empty)
//   rd_data       - head entry, zero while empty
//   full, empty   - occupancy flags
//   count         - number of stored entries
// ---------------------------------------------------------------------------
module dispatch_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its inputs from before the clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // alone define which entries are meaningful, and rd_data is masked to zero
    // while empty.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule : dispatch_result_fifo

// File: rtl/layer_dispatch.sv
// ---------------------------------------------------------------------------
// layer_dispatch
// Sequencer/router for NUM_LAYERS layer engines. A command selects one
// engine, which receives a one-cycle start pulse and then the input stream as
// operand/weight/bias strobes gated by its input-enable. Its results are
// buffered in a FIFO; layer_done pulses only once that FIFO has drained.
// Ports:
//   clock, reset                 - clock, asynchronous active-low reset
//   cmd_valid/cmd_layer/cmd_ready- layer command handshake (accepted in IDLE)
//   abort                        - abandon the active layer, flush results
//   in_data/in_kind/in_valid/in_ready - input stream handshake
//   eng_start                    - one-hot start pulse
//   eng_data, eng_*_valid        - stream copy and one-hot kind strobes
//   eng_input_enable             - per-engine input back-pressure
//   eng_result/_valid, eng_done  - per-engine result stream and completion
//   res_data/res_valid/res_ready - buffered result egress
//   busy, active_layer, layer_done, result_count - status
//   err_overflow, err_bad_layer, err_clear       - sticky error flags
// ---------------------------------------------------------------------------
module layer_dispatch
    import layer_dispatch_pkg::*;
#(
    parameter int NUM_LAYERS   = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int LAYER_SEL_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               cmd_valid,
    input  logic [LAYER_SEL_W-1:0]             cmd_layer,
    output logic                               cmd_ready,
    input  logic                               abort,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic [1:0]                         in_kind,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_LAYERS-1:0]              eng_start,
    output logic [DATA_WIDTH-1:0]              eng_data,
    output logic [NUM_LAYERS-1:0]              eng_op_valid,
    output logic [NUM_LAYERS-1:0]              eng_wt_valid,
    output logic [NUM_LAYERS-1:0]              eng_bias_valid,
    input  logic [NUM_LAYERS-1:0]              eng_input_enable,
    input  logic [NUM_LAYERS*RESULT_WIDTH-1:0] eng_result,
    input  logic [NUM_LAYERS-1:0]              eng_result_valid,
    input  logic [NUM_LAYERS-1:0]              eng_done,
    output logic [RESULT_WIDTH-1:0]            res_data,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic                               busy,
    output logic [LAYER_SEL_W-1:0]             active_layer,
    output logic                               layer_done,
    output logic [RESULT_COUNT_W-1:0]          result_count,
    output logic                               err_overflow,
    output logic                               err_bad_layer,
    input  logic                               err_clear
);

    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Layer count widened by one bit so an out-of-range index compares cleanly.
    localparam logic [LAYER_SEL_W:0] NUM_LAYERS_V = NUM_LAYERS[LAYER_SEL_W:0];

    state_t                    state;
    state_t                    state_next;
    logic [NUM_LAYERS-1:0]     layer_onehot;
    logic [RESULT_WIDTH-1:0]   sel_result;
    logic                      sel_result_valid;
    logic                      sel_done;
    logic                      sel_enable;
    logic                      cmd_bad;
    logic                      accept;
    logic                      bad_cmd;
    logic                      capture_window;
    logic                      capture;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_flush;
    logic [FIFO_CNT_W-1:0]     fifo_count;
    logic                      drain_empty;
    logic                      overflow_set;

    // Decode the latched index once and reuse it for every per-engine select.
    always_comb begin
        layer_onehot     = '0;
        sel_result       = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_onehot[i] = (active_layer == LAYER_SEL_W'(i));
            if (layer_onehot[i]) sel_result = eng_result[i*RESULT_WIDTH +: RESULT_WIDTH];
        end
        sel_result_valid = |(eng_result_valid & layer_onehot);
        sel_done         = |(eng_done & layer_onehot);
        sel_enable       = |(eng_input_enable & layer_onehot);
    end

    assign cmd_bad = ({1'b0, cmd_layer} >= NUM_LAYERS_V);

    // Result capture: abort wins over a same-cycle result. A full FIFO still
    // takes the entry when the head is popped in the same cycle.
    assign capture_window = ((state == ST_STREAM) || (state == ST_DRAIN)) && !abort;
    assign capture        = capture_window && sel_result_valid;
    assign fifo_pop       = res_valid && res_ready;
    assign fifo_push      = capture && (!fifo_full || fifo_pop);
    assign overflow_set   = capture && fifo_full && !fifo_pop;
    assign fifo_flush     = abort && (state != ST_IDLE);

    // Empty after this cycle: nothing arriving and either nothing stored or the
    // last entry is leaving now.
    assign drain_empty = !fifo_push &&
                         (fifo_empty || ((fifo_count == FIFO_CNT_W'(1)) && fifo_pop));

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        cmd_ready      = 1'b0;
        accept         = 1'b0;
        bad_cmd        = 1'b0;
        eng_start      = '0;
        in_ready       = 1'b0;
        eng_data       = '0;
        eng_op_valid   = '0;
        eng_wt_valid   = '0;
        eng_bias_valid = '0;
        layer_done     = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        bad_cmd = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_START;
                    end
                end
            end
            ST_START: begin
                eng_start  = layer_onehot;
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                in_ready = sel_enable;
                eng_data = in_data;
                if (in_valid && sel_enable) begin
                    case (in_kind)
                        KIND_OP:   eng_op_valid   = layer_onehot;
                        KIND_WT:   eng_wt_valid   = layer_onehot;
                        KIND_BIAS: eng_bias_valid = layer_onehot;
                        default:   ; // reserved kind: consumed and discarded
                    endcase
                end
                if (sel_done) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_empty) begin
                    layer_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            layer_done = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            active_layer  <= '0;
            result_count  <= '0;
            err_overflow  <= 1'b0;
            err_bad_layer <= 1'b0;
        end else begin
            state <= state_next;

            if (accept) begin
                active_layer <= cmd_layer;
                result_count <= '0;
            end else if (fifo_push && (result_count != '1)) begin
                result_count <= result_count + 1'b1;
            end

            if (err_clear)         err_overflow <= 1'b0;
            else if (overflow_set) err_overflow <= 1'b1;

            if (err_clear)         err_bad_layer <= 1'b0;
            else if (bad_cmd)      err_bad_layer <= 1'b1;
        end
    end

    dispatch_result_fifo #(
        .WIDTH (RESULT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .wr_data (sel_result),
        .pop     (fifo_pop),
        .rd_data (res_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign res_valid = !fifo_empty;

endmodule : layer_dispatch

// File: tb/tb_layer_dispatch.sv
// ---------------------------------------------------------------------------
// tb_layer_dispatch
// Directed bench for layer_dispatch (NUM_LAYERS=3, FIFO_DEPTH=16): a vector
// table for the stream routing, plus hand-written sequences for results,
// overflow, bad commands, abort and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_layer_dispatch;

    localparam int NL = 3;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int SW = 2;

    logic           clock;
    logic           reset;
    logic           cmd_valid;
    logic [SW-1:0]  cmd_layer;
    logic           cmd_ready;
    logic           abort;
    logic [DW-1:0]  in_data;
    logic [1:0]     in_kind;
    logic           in_valid;
    logic           in_ready;
    logic [NL-1:0]  eng_start;
    logic [DW-1:0]  eng_data;
    logic [NL-1:0]  eng_op_valid;
    logic [NL-1:0]  eng_wt_valid;
    logic [NL-1:0]  eng_bias_valid;
    logic [NL-1:0]  eng_input_enable;
    logic [NL*RW-1:0] eng_result;
    logic [NL-1:0]  eng_result_valid;
    logic [NL-1:0]  eng_done;
    logic [RW-1:0]  res_data;
    logic           res_valid;
    logic           res_ready;
    logic           busy;
    logic [SW-1:0]  active_layer;
    logic           layer_done;
    logic [15:0]    result_count;
    logic           err_overflow;
    logic           err_bad_layer;
    logic           err_clear;

    int n_checks = 0;
    int n_errors = 0;

    layer_dispatch #(
        .NUM_LAYERS   (NL),
        .DATA_WIDTH   (DW),
        .RESULT_WIDTH (RW),
        .FIFO_DEPTH   (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_layer        (cmd_layer),
        .cmd_ready        (cmd_ready),
        .abort            (abort),
        .in_data          (in_data),
        .in_kind          (in_kind),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .eng_start        (eng_start),
        .eng_data         (eng_data),
        .eng_op_valid     (eng_op_valid),
        .eng_wt_valid     (eng_wt_valid),
        .eng_bias_valid   (eng_bias_valid),
        .eng_input_enable (eng_input_enable),
        .eng_result       (eng_result),
        .eng_result_valid (eng_result_valid),
        .eng_done         (eng_done),
        .res_data         (res_data),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .busy             (busy),
        .active_layer     (active_layer),
        .layer_done       (layer_done),
        .result_count     (result_count),
        .err_overflow     (err_overflow),
        .err_bad_layer    (err_bad_layer),
        .err_clear        (err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]    kind;
        logic          valid;
        logic [NL-1:0] en;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic [NL-1:0] exp_op;
        logic [NL-1:0] exp_wt;
        logic [NL-1:0] exp_bias;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_result(input int idx, input logic [RW-1:0] val);
        eng_result[idx*RW +: RW] = val;
    endtask

    task automatic start_layer(input logic [SW-1:0] idx);
        cmd_valid = 1'b1;
        cmd_layer = idx;
        tick();           // accepted -> START
        cmd_valid = 1'b0;
    endtask

    initial begin
        int op_cnt;
        int wt_cnt;
        int bias_cnt;

        //            kind valid en      data          rdy  op      wt      bias
        vecs[0] = '{2'd0, 1'b1, 3'b010, 32'hA000_0001, 1'b1, 3'b010, 3'b000, 3'b000};
        vecs[1] = '{2'd0, 1'b1, 3'b010, 32'hA000_0002, 1'b1, 3'b010, 3'b000, 3'b000};
        vecs[2] = '{2'd1, 1'b1, 3'b010, 32'hB000_0001, 1'b1, 3'b000, 3'b010, 3'b000};
        vecs[3] = '{2'd0, 1'b1, 3'b101, 32'hA000_00FF, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[4] = '{2'd0, 1'b1, 3'b010, 32'hA000_0003, 1'b1, 3'b010, 3'b000, 3'b000};
        vecs[5] = '{2'd2, 1'b1, 3'b111, 32'hC000_0001, 1'b1, 3'b000, 3'b000, 3'b010};
        vecs[6] = '{2'd3, 1'b1, 3'b010, 32'hD000_0001, 1'b1, 3'b000, 3'b000, 3'b000};
        vecs[7] = '{2'd1, 1'b1, 3'b010, 32'hB000_0002, 1'b1, 3'b000, 3'b010, 3'b000};
        vecs[8] = '{2'd0, 1'b0, 3'b010, 32'h0BAD_0000, 1'b1, 3'b000, 3'b000, 3'b000};
        vecs[9] = '{2'd0, 1'b1, 3'b010, 32'hA000_0004, 1'b1, 3'b010, 3'b000, 3'b000};

        reset = 1'b0;
        cmd_valid = 1'b0; cmd_layer = '0; abort = 1'b0;
        in_data = '0; in_kind = '0; in_valid = 1'b0;
        eng_input_enable = '0; eng_result = '0; eng_result_valid = '0; eng_done = '0;
        res_ready = 1'b0; err_clear = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_active_layer", active_layer, 0);
        check("rst_result_count", result_count, 0);
        check("rst_errors", {err_overflow, err_bad_layer}, 0);
        reset = 1'b1;
        tick();

        // ---------------- layer 1 stream routing ----------------
        eng_input_enable = 3'b010;
        check("l1_cmd_ready", cmd_ready, 1);
        start_layer(2'd1);
        in_valid = 1'b1; in_kind = 2'd0;
        #1;
        check("l1_start_pulse", eng_start, 3'b010);
        check("l1_start_busy", busy, 1);
        check("l1_active_layer", active_layer, 1);
        check("l1_start_in_ready", in_ready, 0);
        check("l1_start_no_strobe", eng_op_valid, 0);
        tick();
        check("l1_start_one_cycle", eng_start, 0);
        op_cnt = 0; wt_cnt = 0; bias_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_kind = vecs[i].kind;
            in_valid = vecs[i].valid;
            eng_input_enable = vecs[i].en;
            in_data = vecs[i].data;
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_op", i), eng_op_valid, vecs[i].exp_op);
            check($sformatf("vec%0d_wt", i), eng_wt_valid, vecs[i].exp_wt);
            check($sformatf("vec%0d_bias", i), eng_bias_valid, vecs[i].exp_bias);
            check($sformatf("vec%0d_eng_data", i), eng_data, vecs[i].data);
            op_cnt += $countones(eng_op_valid);
            wt_cnt += $countones(eng_wt_valid);
            bias_cnt += $countones(eng_bias_valid);
            tick();
        end
        check("l1_op_strobes", op_cnt, 4);
        check("l1_wt_strobes", wt_cnt, 2);
        check("l1_bias_strobes", bias_cnt, 1);
        in_valid = 1'b0;
        eng_done = 3'b010;
        tick();           // -> DRAIN with empty FIFO
        eng_done = 3'b000;
        in_valid = 1'b1; in_kind = 2'd0; eng_input_enable = 3'b111;
        #1;
        check("l1_drain_in_ready", in_ready, 0);
        check("l1_drain_no_strobe", eng_op_valid, 0);
        check("l1_layer_done", layer_done, 1);
        check("l1_drain_busy", busy, 1);
        tick();
        in_valid = 1'b0;
        check("l1_done_once", layer_done, 0);
        check("l1_idle", busy, 0);

        // ---------------- layer 0 results in order ----------------
        res_ready = 1'b1;
        start_layer(2'd0);
        set_result(0, 32'hEE); eng_result_valid = 3'b001; eng_done = 3'b001;
        tick();           // START cycle ignored results and done
        check("l0_start_ignored", res_valid, 0);
        check("l0_in_stream", busy, 1);
        set_result(0, 32'h11); set_result(2, 32'h99);
        eng_result_valid = 3'b101; eng_done = 3'b000;
        tick();
        set_result(0, 32'h22);
        check("l0_head_11", res_data, 32'h11);
        check("l0_valid", res_valid, 1);
        tick();
        set_result(0, 32'h33); eng_done = 3'b001;
        check("l0_head_22", res_data, 32'h22);
        tick();           // -> DRAIN, 0x33 captured with done
        eng_result_valid = '0; eng_done = '0;
        #1;
        check("l0_head_33", res_data, 32'h33);
        check("l0_done_on_last_pop", layer_done, 1);
        check("l0_result_count", result_count, 3);
        tick();
        check("l0_done_once", layer_done, 0);
        check("l0_empty", res_valid, 0);
        check("l0_idle", busy, 0);
        check("l0_count_held", result_count, 3);

        // ---------------- layer 2 overflow ----------------
        res_ready = 1'b0;
        start_layer(2'd2);
        tick();           // -> STREAM
        for (int i = 0; i < 17; i++) begin
            set_result(2, RW'(i)); eng_result_valid = 3'b100;
            if (i == 16) begin
                #1;
                check("ov_no_flag_at_16", err_overflow, 0);
                check("ov_count_at_16", result_count, 16);
            end
            tick();
        end
        check("ov_flag", err_overflow, 1);
        check("ov_count_sat_fifo", result_count, 16);
        check("ov_head", res_data, 0);
        set_result(2, 32'h77); err_clear = 1'b1;   // dropped, clear wins
        tick();
        err_clear = 1'b0;
        check("ov_clear_wins", err_overflow, 0);
        check("ov_drop_count", result_count, 16);
        set_result(2, 32'hAA); res_ready = 1'b1;   // push + pop on full
        #1;
        check("ov_head_before_pp", res_data, 0);
        tick();
        eng_result_valid = '0; eng_done = 3'b100;
        #1;
        check("ov_pp_count", result_count, 17);
        check("ov_pp_no_flag", err_overflow, 0);
        check("ov_head_1", res_data, 1);
        tick();           // -> DRAIN
        eng_done = '0;
        for (int k = 2; k < 16; k++) begin
            check($sformatf("ov_drain_%0d", k), res_data, k);
            check($sformatf("ov_drain_nodone_%0d", k), layer_done, 0);
            tick();
        end
        check("ov_drain_last", res_data, 32'hAA);
        check("ov_layer_done", layer_done, 1);
        tick();
        check("ov_idle", busy, 0);
        check("ov_empty", res_valid, 0);

        // ---------------- bad layer index ----------------
        res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_layer = 2'd3;
        #1;
        check("bad_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("bad_flag", err_bad_layer, 1);
        check("bad_busy", busy, 0);
        check("bad_no_start", eng_start, 0);
        tick();
        check("bad_still_idle", busy, 0);
        check("bad_still_no_start", eng_start, 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("bad_cleared", err_bad_layer, 0);

        // ---------------- abort in STREAM ----------------
        start_layer(2'd0);
        tick();           // -> STREAM
        for (int i = 0; i < 5; i++) begin
            set_result(0, 32'h50 + RW'(i)); eng_result_valid = 3'b001;
            tick();
        end
        check("ab_buffered", res_valid, 1);
        check("ab_count5", result_count, 5);
        set_result(0, 32'h55); abort = 1'b1;
        #1;
        check("ab_no_done_in_cycle", layer_done, 0);
        tick();
        abort = 1'b0; eng_result_valid = '0;
        check("ab_flushed", res_valid, 0);
        check("ab_idle", busy, 0);
        check("ab_no_done", layer_done, 0);
        check("ab_count_untouched", result_count, 5);
        cmd_valid = 1'b1; cmd_layer = 2'd2;
        #1;
        check("ab_new_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("ab_new_start", eng_start, 3'b100);

        // ---------------- async reset in DRAIN ----------------
        tick();           // -> STREAM
        for (int i = 0; i < 4; i++) begin
            set_result(2, 32'hC0 + RW'(i)); eng_result_valid = 3'b100;
            tick();
        end
        eng_result_valid = '0; eng_done = 3'b100;
        tick();           // -> DRAIN with 4 entries
        eng_done = '0;
        check("rd_busy", busy, 1);
        check("rd_buffered", res_data, 32'hC0);
        #2;
        reset = 1'b0;
        #1;
        check("rd_async_busy", busy, 0);
        check("rd_async_res_valid", res_valid, 0);
        check("rd_async_res_data", res_data, 0);
        check("rd_async_cmd_ready", cmd_ready, 1);
        check("rd_async_active", active_layer, 0);
        check("rd_async_count", result_count, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rd_release_cmd_ready", cmd_ready, 1);
        check("rd_release_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_layer_dispatch
